// File: rtl/erasure_mask_builder.sv
// Assembles the per-codeword erasure mask for the RS(10,8) erasure decoder from a
// stream of failed-symbol locations, and holds it until downstream takes it.
module erasure_mask_builder #(
  parameter int unsigned NUM_SYMBOLS  = 10,
  parameter int unsigned MAX_ERASURES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   loc_valid_in,
  output logic                   loc_ready_out,
  input  logic [3:0]             loc_in,
  input  logic                   loc_last_in,
  output logic                   mask_valid_out,
  input  logic                   mask_ready_in,
  output logic [NUM_SYMBOLS-1:0] DUE_information_out,
  output logic [1:0]             erasure_cnt_out,
  output logic                   overflow_out,
  output logic                   invalid_out
);

  localparam logic StCollect = 1'b0;
  localparam logic StHold    = 1'b1;

  localparam logic [1:0] MaxCnt = 2'(MAX_ERASURES);
  localparam logic [3:0] NullLoc = 4'hf;
  localparam logic [NUM_SYMBOLS-1:0] LocZeroBit = {1'b1, {(NUM_SYMBOLS - 1){1'b0}}};

  logic                   state_q, state_d;
  logic [NUM_SYMBOLS-1:0] mask_q, mask_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   inv_q, inv_d;

  logic [NUM_SYMBOLS-1:0] loc_bit;
  logic                   loc_hit;
  logic                   loc_dup;

  // Location L maps to bit (NUM_SYMBOLS-1-L); out-of-range locations shift out to zero.
  assign loc_bit = LocZeroBit >> loc_in;
  assign loc_hit = |loc_bit;
  assign loc_dup = |(mask_q & loc_bit);

  assign loc_ready_out       = (state_q == StCollect);
  assign mask_valid_out      = (state_q == StHold);
  assign DUE_information_out = mask_q;
  assign erasure_cnt_out     = cnt_q;
  assign overflow_out        = ovf_q;
  assign invalid_out         = inv_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    inv_d   = inv_q;
    if (state_q == StCollect) begin
      if (loc_valid_in) begin
        if (loc_hit) begin
          mask_d = mask_q | loc_bit;
          if (!loc_dup) begin
            if (cnt_q == MaxCnt) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end else if (loc_in != NullLoc) begin
          inv_d = 1'b1;
        end
        if (loc_last_in) begin
          state_d = StHold;
        end
      end
    end else if (mask_ready_in) begin
      state_d = StCollect;
      mask_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      inv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCollect;
      mask_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: tb/tb_erasure_mask_builder.sv
// Directed bench for erasure_mask_builder; observes the whole output bundle as
// {valid, ready, mask[9:0], cnt[1:0], overflow, invalid}.
module tb_erasure_mask_builder;

  logic       clk;
  logic       rst_n;
  logic       loc_valid_in;
  logic       loc_ready_out;
  logic [3:0] loc_in;
  logic       loc_last_in;
  logic       mask_valid_out;
  logic       mask_ready_in;
  logic [9:0] due_info;
  logic [1:0] erasure_cnt_out;
  logic       overflow_out;
  logic       invalid_out;

  int errors = 0;
  int checks = 0;

  erasure_mask_builder #(
    .NUM_SYMBOLS (10),
    .MAX_ERASURES(2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .loc_valid_in       (loc_valid_in),
    .loc_ready_out      (loc_ready_out),
    .loc_in             (loc_in),
    .loc_last_in        (loc_last_in),
    .mask_valid_out     (mask_valid_out),
    .mask_ready_in      (mask_ready_in),
    .DUE_information_out(due_info),
    .erasure_cnt_out    (erasure_cnt_out),
    .overflow_out       (overflow_out),
    .invalid_out        (invalid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {mask_valid_out, loc_ready_out, due_info, erasure_cnt_out, overflow_out,
                invalid_out};

  function automatic logic [15:0] exp_vec(input logic v, input logic r, input logic [9:0] m,
                                          input logic [1:0] c, input logic o, input logic i);
    return {v, r, m, c, o, i};
  endfunction

  localparam logic [15:0] Idle = 16'h4000;  // ready=1, everything else clear

  // Present one beat; COLLECT always accepts it at the next rising edge.
  task automatic send_beat(input logic [3:0] loc, input logic last);
    loc_valid_in = 1'b1;
    loc_in       = loc;
    loc_last_in  = last;
    @(posedge clk);
    #1;
    loc_valid_in = 1'b0;
    loc_last_in  = 1'b0;
    loc_in       = 4'h0;
  endtask

  task automatic release_result();
    mask_ready_in = 1'b1;
    @(posedge clk);
    #1;
    mask_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs !== Idle) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, Idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== Idle) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, Idle);
    end
  endtask

  task automatic test_two_erasures();
    send_beat(4'd2, 1'b0);
    checks++;
    if (obs !== exp_vec(1'b0, 1'b1, 10'h080, 2'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL partial_loc2: got %h expected %h", obs,
               exp_vec(1'b0, 1'b1, 10'h080, 2'd1, 1'b0, 1'b0));
    end
    send_beat(4'd7, 1'b1);
    checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 10'h084, 2'd2, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL two_erasures: got %h expected %h", obs,
               exp_vec(1'b1, 1'b0, 10'h084, 2'd2, 1'b0, 1'b0));
    end
    release_result();
    checks++;
    if (obs !== Idle) begin
      errors++;
      $display("FAIL release_clear: got %h expected %h", obs, Idle);
    end
  endtask

  task automatic test_duplicate();
    send_beat(4'd0, 1'b0);
    send_beat(4'd0, 1'b0);
    send_beat(4'd15, 1'b1);
    checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 10'h200, 2'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL duplicate: got %h expected %h", obs,
               exp_vec(1'b1, 1'b0, 10'h200, 2'd1, 1'b0, 1'b0));
    end
    release_result();
  endtask

  task automatic test_overflow();
    send_beat(4'd1, 1'b0);
    send_beat(4'd4, 1'b0);
    send_beat(4'd8, 1'b1);
    checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 10'h122, 2'd2, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL overflow: got %h expected %h", obs,
               exp_vec(1'b1, 1'b0, 10'h122, 2'd2, 1'b1, 1'b0));
    end
    release_result();
    checks++;
    if (obs !== Idle) begin
      errors++;
      $display("FAIL overflow_clear: got %h expected %h", obs, Idle);
    end
  endtask

  task automatic test_invalid_and_empty();
    send_beat(4'd12, 1'b0);
    send_beat(4'd3, 1'b1);
    checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 10'h040, 2'd1, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL invalid: got %h expected %h", obs,
               exp_vec(1'b1, 1'b0, 10'h040, 2'd1, 1'b0, 1'b1));
    end
    release_result();
    send_beat(4'd15, 1'b1);
    checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL empty_frame: got %h expected %h", obs,
               exp_vec(1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 1'b0));
    end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    send_beat(4'd3, 1'b1);
    held = exp_vec(1'b1, 1'b0, 10'h040, 2'd1, 1'b0, 1'b0);
    loc_valid_in = 1'b1;
    loc_in       = 4'd6;
    loc_last_in  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== held) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got %h expected %h", i, obs, held);
      end
    end
    mask_ready_in = 1'b1;
    @(posedge clk);
    #1;
    mask_ready_in = 1'b0;
    checks++;
    if (obs !== Idle) begin
      errors++;
      $display("FAIL bp_release: got %h expected %h", obs, Idle);
    end
    // The held loc 6 beat lands in the fresh frame as its only (last) beat.
    @(posedge clk);
    #1;
    loc_valid_in = 1'b0;
    loc_last_in  = 1'b0;
    checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 10'h008, 2'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL bp_pending_beat: got %h expected %h", obs,
               exp_vec(1'b1, 1'b0, 10'h008, 2'd1, 1'b0, 1'b0));
    end
    release_result();
  endtask

  task automatic test_ready_in_collect();
    mask_ready_in = 1'b1;
    send_beat(4'd9, 1'b0);
    mask_ready_in = 1'b0;
    checks++;
    if (obs !== exp_vec(1'b0, 1'b1, 10'h001, 2'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL ready_in_collect: got %h expected %h", obs,
               exp_vec(1'b0, 1'b1, 10'h001, 2'd1, 1'b0, 1'b0));
    end
    send_beat(4'd15, 1'b1);
    release_result();
  endtask

  task automatic test_reset_midframe();
    send_beat(4'd5, 1'b0);
    checks++;
    if (obs !== exp_vec(1'b0, 1'b1, 10'h010, 2'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL midframe_partial: got %h expected %h", obs,
               exp_vec(1'b0, 1'b1, 10'h010, 2'd1, 1'b0, 1'b0));
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== Idle) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, Idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(4'd9, 1'b1);
    checks++;
    if (obs !== exp_vec(1'b1, 1'b0, 10'h001, 2'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL after_reset_frame: got %h expected %h", obs,
               exp_vec(1'b1, 1'b0, 10'h001, 2'd1, 1'b0, 1'b0));
    end
    release_result();
  endtask

  initial begin
    loc_valid_in  = 1'b0;
    loc_in        = 4'h0;
    loc_last_in   = 1'b0;
    mask_ready_in = 1'b0;
    test_reset();
    test_two_erasures();
    test_duplicate();
    test_overflow();
    test_invalid_and_empty();
    test_backpressure();
    test_ready_in_collect();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
